// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle sequencer for the single-issue RV32I datapath.
//
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and
// produces the PC, IR, regfile and data-memory strobes from the registered
// op class plus the imem/dmem handshakes.
//
// Parameters
//   TIMEOUT_CYCLES  wait cycles tolerated on an imem/dmem handshake before a
//                   bus error halts the core; 0 disables the timeout.
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES.
//
// Optional feature macro
//   MC_CTRL_INSTRET_EN  when defined, instret_o is a 32-bit retired-
//                       instruction counter; otherwise it is tied to 0.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous reset, active low
//   opcode_i        instr[6:0] of the latched IR
//   branch_taken_i  branch compare result, meaningful in EXEC
//   imem_valid_i    instruction data valid this cycle
//   dmem_ready_i    data access completes this cycle
//   imem_req_o      instruction fetch request
//   ir_we_o         IR load pulse
//   dmem_req_o      data memory request
//   dmem_we_o       data memory write (store)
//   pc_we_o         PC update strobe
//   pc_sel_o        0=pc+4, 1=pc+imm, 2=(rs1+imm)&~1
//   rf_we_o         regfile write enable
//   wb_sel_o        0=ALU, 1=load data, 2=pc+4, 3=imm
//   alu_src_b_o     0=rs2, 1=imm
//   retire_o        one pulse per completed instruction
//   halt_o          core halted (sticky until reset)
//   illegal_o       halted on an illegal opcode (sticky)
//   bus_err_o       halted on a handshake timeout (sticky)
//   state_o         current state encoding
//   instret_o       retired-instruction count
// ---------------------------------------------------------------------------
module mc_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic        branch_taken_i,
  input  logic        imem_valid_i,
  input  logic        dmem_ready_i,
  output logic        imem_req_o,
  output logic        ir_we_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        alu_src_b_o,
  output logic        retire_o,
  output logic        halt_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [2:0]  state_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Class code k (1..9) corresponds to entry k-1 of the legal opcode table.
  typedef enum logic [3:0] {
    C_NONE   = 4'd0,
    C_LUI    = 4'd1,
    C_AUIPC  = 4'd2,
    C_JAL    = 4'd3,
    C_JALR   = 4'd4,
    C_BRANCH = 4'd5,
    C_LOAD   = 4'd6,
    C_STORE  = 4'd7,
    C_OPIMM  = 4'd8,
    C_OP     = 4'd9
  } cls_t;

  localparam int NUM_OPC = 9;

  // Packed table, index 0 (LUI) in the least significant slot.
  localparam logic [NUM_OPC-1:0][6:0] LEGAL_OPC = {
    7'b0110011,  // OP
    7'b0010011,  // OP-IMM
    7'b0100011,  // STORE
    7'b0000011,  // LOAD
    7'b1100011,  // BRANCH
    7'b1100111,  // JALR
    7'b1101111,  // JAL
    7'b0010111,  // AUIPC
    7'b0110111   // LUI
  };

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // The wait that would bring the count up to TIMEOUT_CYCLES is the last one
  // tolerated; a handshake in that same cycle still completes normally.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t           state_reg;
  state_t           state_next;
  cls_t             cls_reg;
  cls_t             dec_cls;
  logic [CNT_W-1:0] cnt_reg;
  logic             illegal_reg;
  logic             bus_err_reg;
  logic             set_illegal;
  logic             set_bus_err;
  logic             wait_expired;
  logic             opc_legal;
  logic [NUM_OPC-1:0] opc_hit;

  // -------------------------------------------------------------------------
  // Opcode decode: one comparator per legal opcode, then a one-hot to class.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPC; gi++) begin : g_opc_match
      assign opc_hit[gi] = (opcode_i == LEGAL_OPC[gi]);
    end
  endgenerate

  assign opc_legal = |opc_hit;

  always_comb begin
    dec_cls = C_NONE;
    for (int i = 0; i < NUM_OPC; i++) begin
      if (opc_hit[i]) begin
        dec_cls = cls_t'(4'(i + 1));
      end
    end
  end

  assign wait_expired = TIMEOUT_EN && (cnt_reg == CNT_LAST);

  // -------------------------------------------------------------------------
  // FSM process 1: state register (plus the per-instruction bookkeeping that
  // moves with it).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Op class is captured once, in DECODE, and steers the rest of the
  // instruction; outputs never look at opcode_i directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_reg <= C_NONE;
    end else if (state_reg == S_DECODE) begin
      cls_reg <= dec_cls;
    end
  end

  // Wait counter: cleared on every state change (so on entry to FETCH/MEM),
  // advanced only on cycles spent waiting for a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if ((state_reg == S_FETCH && !imem_valid_i) ||
                 (state_reg == S_MEM   && !dmem_ready_i)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Halt-cause flags only ever set; HALT is absorbing so they stay put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      if (set_illegal) illegal_reg <= 1'b1;
      if (set_bus_err) bus_err_reg <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid_i) begin
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        if (opc_legal) begin
          state_next = S_EXEC;
        end else if (opcode_i == OPC_SYSTEM) begin
          state_next = S_HALT;
        end else begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXEC: begin
        case (cls_reg)
          C_BRANCH:        state_next = S_FETCH;
          C_LOAD, C_STORE: state_next = S_MEM;
          default:         state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready_i) begin
          state_next = (cls_reg == C_STORE) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output decode from state + registered class. The FETCH
  // and MEM exit strobes additionally follow the same-cycle handshake.
  // -------------------------------------------------------------------------
  logic uses_imm;
  assign uses_imm = (cls_reg != C_OP) && (cls_reg != C_BRANCH) &&
                    (cls_reg != C_NONE);

  always_comb begin
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 2'd0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 2'd0;
    alu_src_b_o = 1'b0;
    retire_o    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_valid_i;
      end
      S_EXEC: begin
        alu_src_b_o = uses_imm;
        if (cls_reg == C_BRANCH) begin
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? 2'd1 : 2'd0;
          retire_o = 1'b1;
        end
      end
      S_MEM: begin
        alu_src_b_o = uses_imm;
        dmem_req_o  = 1'b1;
        dmem_we_o   = (cls_reg == C_STORE);
        // A store finishes here; a load still has its WB cycle to go.
        if (dmem_ready_i && cls_reg == C_STORE) begin
          pc_we_o  = 1'b1;
          pc_sel_o = 2'd0;
          retire_o = 1'b1;
        end
      end
      S_WB: begin
        alu_src_b_o = uses_imm;
        rf_we_o     = 1'b1;
        pc_we_o     = 1'b1;
        retire_o    = 1'b1;
        case (cls_reg)
          C_LOAD:        wb_sel_o = 2'd1;
          C_JAL, C_JALR: wb_sel_o = 2'd2;
          C_LUI:         wb_sel_o = 2'd3;
          default:       wb_sel_o = 2'd0;
        endcase
        case (cls_reg)
          C_JAL:   pc_sel_o = 2'd1;
          C_JALR:  pc_sel_o = 2'd2;
          default: pc_sel_o = 2'd0;
        endcase
      end
      default: begin
      end
    endcase
  end

  assign halt_o    = (state_reg == S_HALT);
  assign illegal_o = illegal_reg;
  assign bus_err_o = bus_err_reg;
  assign state_o   = state_reg;

  // -------------------------------------------------------------------------
  // Retired-instruction counter (optional).
  // -------------------------------------------------------------------------
`ifdef MC_CTRL_INSTRET_EN
  logic [31:0] instret_reg;

  // Free-running 32-bit count; wraps naturally from all-ones to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_reg <= '0;
    end else if (retire_o) begin
      instret_reg <= instret_reg + 32'd1;
    end
  end

  assign instret_o = instret_reg;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl (TIMEOUT_CYCLES = 4).
// Each step drives one cycle of inputs at the falling edge, pushes the
// expected output word onto a scoreboard queue, and pops/compares it 1 ns
// later. Expected output word layout (18 bits, MSB first):
//   state[3] imem_req ir_we dmem_req dmem_we pc_we pc_sel[2] rf_we
//   wb_sel[2] alu_src_b retire halt illegal bus_err
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode_i = 7'd0;
  logic        branch_taken_i = 1'b0;
  logic        imem_valid_i = 1'b0;
  logic        dmem_ready_i = 1'b0;
  logic        imem_req_o;
  logic        ir_we_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        pc_we_o;
  logic [1:0]  pc_sel_o;
  logic        rf_we_o;
  logic [1:0]  wb_sel_o;
  logic        alu_src_b_o;
  logic        retire_o;
  logic        halt_o;
  logic        illegal_o;
  logic        bus_err_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  mc_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode_i      (opcode_i),
    .branch_taken_i(branch_taken_i),
    .imem_valid_i  (imem_valid_i),
    .dmem_ready_i  (dmem_ready_i),
    .imem_req_o    (imem_req_o),
    .ir_we_o       (ir_we_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .pc_we_o       (pc_we_o),
    .pc_sel_o      (pc_sel_o),
    .rf_we_o       (rf_we_o),
    .wb_sel_o      (wb_sel_o),
    .alu_src_b_o   (alu_src_b_o),
    .retire_o      (retire_o),
    .halt_o        (halt_o),
    .illegal_o     (illegal_o),
    .bus_err_o     (bus_err_o),
    .state_o       (state_o),
    .instret_o     (instret_o)
  );

  always #5 clk = ~clk;

  // Opcodes
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  // Expected output words
  localparam logic [17:0] X_IDLE = 18'b000_0_0_0_0_0_00_0_00_0_0_0_0_0;
  localparam logic [17:0] X_FV   = 18'b001_1_1_0_0_0_00_0_00_0_0_0_0_0;
  localparam logic [17:0] X_FW   = 18'b001_1_0_0_0_0_00_0_00_0_0_0_0_0;
  localparam logic [17:0] X_DEC  = 18'b010_0_0_0_0_0_00_0_00_0_0_0_0_0;
  localparam logic [17:0] X_EXI  = 18'b011_0_0_0_0_0_00_0_00_1_0_0_0_0;
  localparam logic [17:0] X_EXR  = 18'b011_0_0_0_0_0_00_0_00_0_0_0_0_0;
  localparam logic [17:0] X_BRT  = 18'b011_0_0_0_0_1_01_0_00_0_1_0_0_0;
  localparam logic [17:0] X_BRN  = 18'b011_0_0_0_0_1_00_0_00_0_1_0_0_0;
  localparam logic [17:0] X_WBI  = 18'b101_0_0_0_0_1_00_1_00_1_1_0_0_0;
  localparam logic [17:0] X_WBR  = 18'b101_0_0_0_0_1_00_1_00_0_1_0_0_0;
  localparam logic [17:0] X_WBJ  = 18'b101_0_0_0_0_1_01_1_10_1_1_0_0_0;
  localparam logic [17:0] X_WBJR = 18'b101_0_0_0_0_1_10_1_10_1_1_0_0_0;
  localparam logic [17:0] X_WBU  = 18'b101_0_0_0_0_1_00_1_11_1_1_0_0_0;
  localparam logic [17:0] X_WBL  = 18'b101_0_0_0_0_1_00_1_01_1_1_0_0_0;
  localparam logic [17:0] X_STW  = 18'b100_0_0_1_1_0_00_0_00_1_0_0_0_0;
  localparam logic [17:0] X_STD  = 18'b100_0_0_1_1_1_00_0_00_1_1_0_0_0;
  localparam logic [17:0] X_LDW  = 18'b100_0_0_1_0_0_00_0_00_1_0_0_0_0;
  localparam logic [17:0] X_HI   = 18'b110_0_0_0_0_0_00_0_00_0_0_1_1_0;
  localparam logic [17:0] X_HS   = 18'b110_0_0_0_0_0_00_0_00_0_0_1_0_0;
  localparam logic [17:0] X_HB   = 18'b110_0_0_0_0_0_00_0_00_0_0_1_0_1;

  localparam int RET_BIT = 3;

  typedef struct {
    logic        r;
    logic [6:0]  opc;
    logic        tk;
    logic        iv;
    logic        dr;
    logic [17:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [17:0] out;
    logic [31:0] instret;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_no = 0;
  logic [31:0] model_instret = 32'd0;

  function automatic vec_t mk(input logic r, input logic [6:0] opc,
                              input logic tk, input logic iv, input logic dr,
                              input logic [17:0] exp);
    vec_t v;
    v.r = r; v.opc = opc; v.tk = tk; v.iv = iv; v.dr = dr; v.exp = exp;
    return v;
  endfunction

  task automatic step(input vec_t v);
    sb_t         e;
    sb_t         got_e;
    logic [17:0] got;
    @(negedge clk);
    rst            = v.r;
    opcode_i       = v.opc;
    branch_taken_i = v.tk;
    imem_valid_i   = v.iv;
    dmem_ready_i   = v.dr;
    if (!v.r) model_instret = 32'd0;
    e.idx = vec_no;
    e.out = v.exp;
`ifdef MC_CTRL_INSTRET_EN
    e.instret = model_instret;
`else
    e.instret = 32'd0;
`endif
    sb.push_back(e);
    #1;
    got = {state_o, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o,
           pc_sel_o, rf_we_o, wb_sel_o, alu_src_b_o, retire_o, halt_o,
           illegal_o, bus_err_o};
    got_e = sb.pop_front();
    checks++;
    if (got !== got_e.out || instret_o !== got_e.instret) begin
      errors++;
      $display("FAIL vec%0d outputs got=%b instret=%0d expected=%b instret=%0d",
               got_e.idx, got, instret_o, got_e.out, got_e.instret);
    end else begin
      $display("vec %0d rst=%0d opc=%b tk=%0d iv=%0d dr=%0d out=%b instret=%0d",
               got_e.idx, v.r, v.opc, v.tk, v.iv, v.dr, got, instret_o);
    end
    if (v.r && v.exp[RET_BIT]) model_instret = model_instret + 32'd1;
    vec_no++;
  endtask

  task automatic s(input logic r, input logic [6:0] opc, input logic tk,
                   input logic iv, input logic dr, input logic [17:0] exp);
    step(mk(r, opc, tk, iv, dr, exp));
  endtask

  initial begin
    // ---------------- table: one entry per clock cycle ----------------
    // reset held 3 cycles, then release (still IDLE before the next edge)
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_IMM, 0, 1, 1, X_IDLE));
    tbl.push_back(mk(1, OP_IMM, 0, 0, 0, X_IDLE));
    // ADDI, zero-wait: 4 cycles
    tbl.push_back(mk(1, OP_IMM, 0, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_IMM, 0, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_IMM, 0, 1, 1, X_EXI));
    tbl.push_back(mk(1, OP_IMM, 0, 1, 1, X_WBI));
    // BEQ taken: 3 cycles, no WB
    tbl.push_back(mk(1, OP_BR, 1, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_BR, 1, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_BR, 1, 1, 1, X_BRT));
    // BEQ not taken, with one fetch wait
    tbl.push_back(mk(1, OP_BR, 0, 0, 1, X_FW));
    tbl.push_back(mk(1, OP_BR, 0, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_BR, 0, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_BR, 0, 1, 1, X_BRN));
    // JAL
    tbl.push_back(mk(1, OP_JAL, 0, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_JAL, 0, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_JAL, 0, 1, 1, X_EXI));
    tbl.push_back(mk(1, OP_JAL, 0, 1, 1, X_WBJ));
    // JALR
    tbl.push_back(mk(1, OP_JALR, 0, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_JALR, 0, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_JALR, 0, 1, 1, X_EXI));
    tbl.push_back(mk(1, OP_JALR, 0, 1, 1, X_WBJR));
    // LUI
    tbl.push_back(mk(1, OP_LUI, 0, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_LUI, 0, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_LUI, 0, 1, 1, X_EXI));
    tbl.push_back(mk(1, OP_LUI, 0, 1, 1, X_WBU));
    // STORE, 3 wait cycles then ready
    tbl.push_back(mk(1, OP_ST, 0, 1, 0, X_FV));
    tbl.push_back(mk(1, OP_ST, 0, 1, 0, X_DEC));
    tbl.push_back(mk(1, OP_ST, 0, 1, 0, X_EXI));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, OP_ST, 0, 1, 0, X_STW));
    tbl.push_back(mk(1, OP_ST, 0, 1, 1, X_STD));
    // LOAD, 3 wait cycles then ready on the cycle the count would expire
    tbl.push_back(mk(1, OP_LD, 0, 1, 0, X_FV));
    tbl.push_back(mk(1, OP_LD, 0, 1, 0, X_DEC));
    tbl.push_back(mk(1, OP_LD, 0, 1, 0, X_EXI));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, OP_LD, 0, 1, 0, X_LDW));
    tbl.push_back(mk(1, OP_LD, 0, 1, 1, X_LDW));
    tbl.push_back(mk(1, OP_LD, 0, 1, 1, X_WBL));
    // OP (register-register): alu_src_b stays 0
    tbl.push_back(mk(1, OP_REG, 0, 1, 1, X_FV));
    tbl.push_back(mk(1, OP_REG, 0, 1, 1, X_DEC));
    tbl.push_back(mk(1, OP_REG, 0, 1, 1, X_EXR));
    tbl.push_back(mk(1, OP_REG, 0, 1, 1, X_WBR));

    foreach (tbl[i]) step(tbl[i]);

    // ---------------- hand-written multi-cycle corner cases ----------------
    // Reset asserted in the WB cycle: no write/pc strobe leaks out.
    s(1, OP_IMM, 0, 1, 1, X_FV);
    s(1, OP_IMM, 0, 1, 1, X_DEC);
    s(1, OP_IMM, 0, 1, 1, X_EXI);
    s(0, OP_IMM, 0, 1, 1, X_IDLE);
    s(1, OP_IMM, 0, 1, 1, X_IDLE);

    // Three ADDIs from a fresh count.
    for (int k = 0; k < 3; k++) begin
      s(1, OP_IMM, 0, 1, 1, X_FV);
      s(1, OP_IMM, 0, 1, 1, X_DEC);
      s(1, OP_IMM, 0, 1, 1, X_EXI);
      s(1, OP_IMM, 0, 1, 1, X_WBI);
    end

    // Illegal opcode: HALT next cycle, sticky, no strobes for 10 cycles.
    s(1, OP_BAD, 0, 1, 1, X_FV);
    s(1, OP_BAD, 0, 1, 1, X_DEC);
    for (int k = 0; k < 10; k++) s(1, OP_IMM, k[0], 1, 1, X_HI);

    // SYSTEM: clean halt, no illegal flag.
    s(0, OP_SYS, 0, 0, 0, X_IDLE);
    s(1, OP_SYS, 0, 0, 0, X_IDLE);
    s(1, OP_SYS, 0, 1, 1, X_FV);
    s(1, OP_SYS, 0, 1, 1, X_DEC);
    s(1, OP_SYS, 0, 1, 1, X_HS);
    s(1, OP_SYS, 0, 1, 1, X_HS);

    // Fetch timeout: imem never valid -> bus error after 4 waits.
    s(0, OP_IMM, 0, 0, 0, X_IDLE);
    s(1, OP_IMM, 0, 0, 0, X_IDLE);
    for (int k = 0; k < 4; k++) s(1, OP_IMM, 0, 0, 0, X_FW);
    s(1, OP_IMM, 0, 1, 1, X_HB);
    s(1, OP_IMM, 0, 1, 1, X_HB);

    // Data timeout: dmem_ready stuck low -> bus error after 4 MEM waits.
    s(0, OP_LD, 0, 0, 0, X_IDLE);
    s(1, OP_LD, 0, 0, 0, X_IDLE);
    s(1, OP_LD, 0, 1, 0, X_FV);
    s(1, OP_LD, 0, 1, 0, X_DEC);
    s(1, OP_LD, 0, 1, 0, X_EXI);
    for (int k = 0; k < 4; k++) s(1, OP_LD, 0, 1, 0, X_LDW);
    for (int k = 0; k < 3; k++) s(1, OP_LD, 0, 1, 0, X_HB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32I datapath: pc_reg, imem, decode, regfile, ALU and data memory port. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It generates the PC, IR, regfile and data-memory strobes from the decoded opcode and memory handshakes. It replaces the hard-wired pc+4 / we=0 tie-offs in core_top.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles on imem or dmem handshake before bus error; 0 = no timeout
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
opcode_i  input  7  opcode from decode (instr[6:0] of latched IR)
branch_taken_i  input  1  branch compare result from ALU, valid in EXEC
imem_valid_i  input  1  instruction data valid this cycle
dmem_ready_i  input  1  data access complete this cycle
imem_req_o  output  1  instruction fetch request
ir_we_o  output  1  latch instruction register (1-cycle pulse)
dmem_req_o  output  1  data memory request
dmem_we_o  output  1  data memory write (store)
pc_we_o  output  1  PC update strobe
pc_sel_o  output  2  0=pc+4, 1=pc+imm (branch/JAL), 2=(rs1+imm)&~1 (JALR)
rf_we_o  output  1  regfile write enable
wb_sel_o  output  2  0=ALU, 1=load data, 2=pc+4, 3=imm (LUI)
alu_src_b_o  output  1  0=rs2, 1=imm
retire_o  output  1  1-cycle pulse per completed instruction
halt_o  output  1  sticky halt
illegal_o  output  1  sticky: halted on illegal opcode
bus_err_o  output  1  sticky: halted on handshake timeout
state_o  output  3  current state encoding
instret_o  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0; op-class register cleared.
- IDLE: all strobes 0. Always moves to FETCH on the next clk.
- FETCH: imem_req_o=1. When imem_valid_i=1, ir_we_o=1 that same cycle and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: register the op class from opcode_i.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011 -> EXEC.
  - 1110011 (SYSTEM) -> HALT with halt_o=1.
  - Any other opcode -> HALT with halt_o=1 and illegal_o=1.
- EXEC: alu_src_b_o=1 for all classes except OP and BRANCH.
  - BRANCH: pc_we_o=1, pc_sel_o=branch_taken_i?1:0, retire_o=1 -> FETCH.
  - LOAD/STORE -> MEM.
  - Other classes -> WB.
- MEM: dmem_req_o=1; dmem_we_o=1 for STORE. Stay until dmem_ready_i=1.
  - STORE: on ready, pc_we_o=1, pc_sel_o=0, retire_o=1 -> FETCH.
  - LOAD: on ready -> WB.
- WB: rf_we_o=1, pc_we_o=1, retire_o=1 -> FETCH. Per class:
  - wb_sel_o: LOAD=1; JAL/JALR=2; LUI=3; else 0.
  - pc_sel_o: JAL=1; JALR=2; else 0.
- alu_src_b_o is held for the whole instruction (EXEC through WB/MEM). It is 0 outside EXEC/MEM/WB.
- Outputs are decoded from state plus the registered op class. ir_we_o and the MEM/FETCH exit strobes also depend on the same-cycle handshake input.
- Latency with zero-wait memories:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles, FETCH to WB inclusive.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Timeout: the counter clears on entry to FETCH or MEM and increments each wait cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no handshake, go to HALT with halt_o=1 and bus_err_o=1.
- A handshake arriving in the same cycle the count is reached wins: no error.
- HALT: absorbing until reset. All strobes 0. halt_o, illegal_o and bus_err_o hold.
- Reset asserted mid-instruction: immediate return to IDLE. No partial pc_we_o or rf_we_o pulse is emitted.

Optional Feature:
MC_CTRL_INSTRET_EN:
- Defined: instret_o is a 32-bit counter, reset 0, incremented on every retire_o pulse, wraps 0xFFFFFFFF -> 0.
- Undefined: instret_o tied to 0 and no counter logic is present.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> every output 0 and state_o=0. First clk after release -> state_o=1, imem_req_o=1.
- ADDI (0010011), imem_valid_i=1 in FETCH, then 1-1-1-1 for 4 cycles -> ir_we_o in cycle 1. In cycle 4: rf_we_o=1, wb_sel_o=0, pc_we_o=1, pc_sel_o=0, retire_o=1. Then back in FETCH.
- LOAD (0000011), dmem_ready_i low 3 cycles then high -> dmem_req_o=1 for 4 cycles with dmem_we_o=0, then WB with wb_sel_o=1. STORE (0100011) same timing -> dmem_we_o=1 and rf_we_o never 1.
- BEQ (1100011) with branch_taken_i=1 -> EXEC shows pc_we_o=1, pc_sel_o=1, retire_o=1, and no WB state. With branch_taken_i=0 -> pc_sel_o=0.
- JALR (1100111) -> WB shows wb_sel_o=2, pc_sel_o=2. JAL (1101111) -> pc_sel_o=1. LUI (0110111) -> wb_sel_o=3.
- Opcode 0000000 -> HALT next cycle, illegal_o=1 and no strobes for 10 cycles. TIMEOUT_CYCLES=4 with dmem_ready_i stuck 0 -> bus_err_o=1 after 4 MEM wait cycles. With MC_CTRL_INSTRET_EN defined, 3 ADDIs -> instret_o=3.
